mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Shares one pipelined signed multiplier among NUM_REQ requesters in the demodulator datapath, for example I/Q mixer products and FIR tap products.
- Arbitration is round-robin, so no requester can monopolise the multiplier.
- Each accepted operand pair is tagged with its requester ID.
- The product and its tag are presented on a single valid/ready output port.
- Full-pipeline backpressure comes from the downstream consumer.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- A_DATA_W, 16, signed operand A width.
- B_DATA_W, 24, signed operand B width.
- LAT, 2, multiplier pipeline depth in register stages; legal range 1..4.
- ID_W, $clog2(NUM_REQ), width of the requester tag (derived).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- i_req_valid  input  NUM_REQ  per-requester operand valid.
- i_req_a  input  NUM_REQ*A_DATA_W  packed signed A operands; requester k occupies bits [k*A_DATA_W +: A_DATA_W].
- i_req_b  input  NUM_REQ*B_DATA_W  packed signed B operands; same packing as i_req_a.
- o_req_ready  output  NUM_REQ  one-hot grant; requester k's operands are accepted when i_req_valid[k] && o_req_ready[k].
- i_ready  input  1  downstream consumer can accept o_c/o_id.
- o_c  output  A_DATA_W+B_DATA_W  signed product.
- o_id  output  ID_W  index of the requester that issued o_c.
- o_valid  output  1  o_c/o_id are valid.
- o_busy  output  1  at least one pipeline stage holds a valid transaction.

Behaviour:
- Reset (synchronous, active-high):
  - Clears all stage valid bits, so o_valid=0 and o_busy=0.
  - o_c=0, o_id=0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset asserted mid-operation drops in-flight transactions without emitting them.
  - o_req_ready=0 while reset is high.
- Advance:
  - adv = !o_valid || i_ready.
  - When adv=1, every stage shifts one position and stage 0 loads the accepted request, or a bubble if none.
  - When adv=0, every stage holds its value, the output holds stable, and no grant is issued.
- Grant (combinational from i_req_valid, RR pointer and adv):
  - When adv=1, grant the first k with i_req_valid[k]=1, searching cyclically from pointer+1.
  - o_req_ready is at most one-hot. It is zero when adv=0 or when no request is valid.
  - Requesters must not make i_req_valid depend on o_req_ready.
  - Once a requester asserts valid, it holds valid and its operands stable until accepted.
- Pointer: updates to the granted index only on an accepted transfer. With no accept it is unchanged.
- Arithmetic:
  - o_c = signed(A) * signed(B) at full width. No rounding, saturation or truncation.
  - Example: -32768 * -8388608 = +274877906944.
- Latency:
  - A request accepted on edge t appears at o_valid/o_c/o_id after edge t+LAT-1, provided adv stays 1.
  - With LAT=1 the product is registered on the accepting edge.
  - Stall cycles add latency one-for-one.
- Throughput: one product per cycle when i_ready=1 continuously.
- Ordering: outputs emerge in acceptance order.
- Output handshake:
  - A transfer occurs when o_valid && i_ready.
  - o_valid and the output data never change while o_valid=1 && i_ready=0.
  - There is no combinational path from i_ready to o_valid or o_c.
- o_busy = OR of all stage valid bits.
- Simultaneous events:
  - A request accepted in the same cycle as an output transfer is legal; the pipeline shifts.
  - If all NUM_REQ requesters are valid every cycle, the grant sequence is 0,1,2,…,NUM_REQ-1,0,…
- Bubbles: bubbles are not collapsed. A stall freezes the whole pipeline, including empty stages.

Test Plan:
1. Reset, then requester 2 sends A=3, B=-5 with i_ready=1, LAT=2 -> o_req_ready=4'b0100 that cycle; o_valid=1 with o_c=-15 and o_id=2 exactly 2 edges after acceptance, for one cycle.
2. All 4 requesters valid continuously, each with A=k+1 and B=10, i_ready=1 -> grants 0,1,2,3,0,… on consecutive cycles; outputs (o_id,o_c)=(0,10),(1,20),(2,30),(3,40) back-to-back.
3. Streaming as in scenario 2, then i_ready=0 for 3 cycles -> o_valid/o_c/o_id held stable and o_req_ready=0 throughout; after i_ready=1, the sequence resumes with no loss or duplication.
4. Extreme operands A=-32768, B=-8388608 -> o_c=274877906944. Also A=32767, B=-8388608 -> o_c=-274869518336.
5. Requesters 1 and 3 valid, last grant was 1 -> next grant is 3, then 1. A requester dropping valid leaves the pointer unchanged.
6. Reset asserted with 2 transactions in flight -> o_valid=0 and o_busy=0 on the next cycle with no stale output; after release, requester 0 wins the first simultaneous 0/1 contention.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ
// requesters; products leave tagged with the issuing requester's index.

module mult_arbiter_stage #(
   parameter int P_W  = 40,
   parameter int ID_W = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            adv,
   input  logic [P_W-1:0]  in_c,
   input  logic [ID_W-1:0] in_id,
   output logic [P_W-1:0]  out_c,
   output logic [ID_W-1:0] out_id
);
   always_ff @(posedge clk) begin
      if (reset) begin
         out_c  <= '0;
         out_id <= '0;
      end else if (adv) begin
         out_c  <= in_c;
         out_id <= in_id;
      end
   end
endmodule

module mult_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int A_DATA_W = 16,
   parameter int B_DATA_W = 24,
   parameter int LAT      = 2,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   input  logic [NUM_REQ*A_DATA_W-1:0]  i_req_a,
   input  logic [NUM_REQ*B_DATA_W-1:0]  i_req_b,
   output logic [NUM_REQ-1:0]           o_req_ready,
   input  logic                         i_ready,
   output logic [A_DATA_W+B_DATA_W-1:0] o_c,
   output logic [ID_W-1:0]              o_id,
   output logic                         o_valid,
   output logic                         o_busy
);
   localparam int P_W    = A_DATA_W + B_DATA_W;
   localparam int STAGES = LAT - 1;

   if (NUM_REQ < 2 || NUM_REQ > 16 || LAT < 1 || LAT > 4) begin : g_bad_param
      $error("mult_arbiter: NUM_REQ must be 2..16 and LAT 1..4");
   end

   logic [STAGES:0]                 vld_pipe;
   logic [STAGES:0][P_W-1:0]        c_pipe;
   logic [STAGES:0][ID_W-1:0]       id_pipe;
   logic [ID_W-1:0]                 ptr;
   logic [ID_W-1:0]                 gnt_idx;
   logic [NUM_REQ-1:0]              grant;
   logic                            found;
   logic                            adv;
   logic                            accept;
   logic signed [A_DATA_W-1:0]      a_sel;
   logic signed [B_DATA_W-1:0]      b_sel;
   logic signed [P_W-1:0]           prod;

   // A stall freezes every stage, bubbles included, so the output never
   // depends combinationally on i_ready.
   assign adv     = !o_valid || i_ready;
   assign o_valid = vld_pipe[STAGES];
   assign o_c     = c_pipe[STAGES];
   assign o_id    = id_pipe[STAGES];
   assign o_busy  = |vld_pipe;

   // Cyclic search starting just after the last granted requester.
   always_comb begin
      int k;
      k       = 0;
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         k = (int'(ptr) + i) % NUM_REQ;
         if (!found && i_req_valid[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            gnt_idx  = ID_W'(k);
         end
      end
   end

   assign o_req_ready = (adv && !reset) ? grant : '0;
   assign accept      = found && adv && !reset;

   assign a_sel = i_req_a[gnt_idx*A_DATA_W +: A_DATA_W];
   assign b_sel = i_req_b[gnt_idx*B_DATA_W +: B_DATA_W];
   assign prod  = P_W'(a_sel) * P_W'(b_sel);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         ptr      <= ID_W'(NUM_REQ - 1);
      end else begin
         if (adv) begin
            vld_pipe[0] <= accept;
            for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
         end
         if (accept) ptr <= gnt_idx;
      end
   end

   for (genvar s = 0; s <= STAGES; s++) begin : g_stage
      if (s == 0) begin : g_first
         mult_arbiter_stage #(.P_W(P_W), .ID_W(ID_W)) u_stage (
            .clk(clk), .reset(reset), .adv(adv),
            .in_c(prod), .in_id(gnt_idx),
            .out_c(c_pipe[s]), .out_id(id_pipe[s])
         );
      end else begin : g_next
         mult_arbiter_stage #(.P_W(P_W), .ID_W(ID_W)) u_stage (
            .clk(clk), .reset(reset), .adv(adv),
            .in_c(c_pipe[s-1]), .in_id(id_pipe[s-1]),
            .out_c(c_pipe[s]), .out_id(id_pipe[s])
         );
      end
   end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter at default parameters (4 requesters, LAT=2).

module tb_mult_arbiter;
   logic               clk = 1'b0;
   logic               reset;
   logic [3:0]         req_valid;
   logic [63:0]        req_a;
   logic [95:0]        req_b;
   logic [3:0]         o_req_ready;
   logic               i_ready;
   logic signed [39:0] o_c;
   logic [1:0]         o_id;
   logic               o_valid;
   logic               o_busy;
   int                 total = 0;
   int                 bad = 0;

   mult_arbiter dut (
      .clk(clk), .reset(reset), .i_req_valid(req_valid), .i_req_a(req_a),
      .i_req_b(req_b), .o_req_ready(o_req_ready), .i_ready(i_ready),
      .o_c(o_c), .o_id(o_id), .o_valid(o_valid), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int k, input int a, input int b);
      req_a[k*16 +: 16] = 16'(a);
      req_b[k*24 +: 24] = 24'(b);
   endtask

   task automatic do_reset();
      reset = 1'b1; req_valid = '0; i_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 4'b1111; i_ready = 1'b1;
      tick(); tick();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", o_valid); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", o_busy); end
      total++; if (o_c !== 40'sd0) begin bad++; $display("FAIL rst_c got=%0d want=0", o_c); end
      total++; if (o_id !== 2'd0) begin bad++; $display("FAIL rst_id got=%0d want=0", o_id); end
      total++; if (o_req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b want=0000", o_req_ready); end
      reset = 1'b0; req_valid = '0;
   endtask

   task automatic test_single();
      do_reset();
      set_req(2, 3, -5); req_valid = 4'b0100; i_ready = 1'b1;
      #1;
      total++; if (o_req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b want=0100", o_req_ready); end
      tick(); req_valid = '0; #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", o_valid); end
      total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", o_busy); end
      tick();
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", o_valid); end
      total++; if (o_c !== -40'sd15) begin bad++; $display("FAIL single_c got=%0d want=-15", o_c); end
      total++; if (o_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d want=2", o_id); end
      tick();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL single_once got=%b want=0", o_valid); end
   endtask

   task automatic test_stream();
      do_reset();
      for (int k = 0; k < 4; k++) set_req(k, k + 1, 10);
      req_valid = 4'b1111; i_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         total++;
         if (o_req_ready !== 4'(1 << (c % 4))) begin
            bad++; $display("FAIL stream_grant c=%0d got=%b want=%b", c, o_req_ready, 4'(1 << (c % 4)));
         end
         total++;
         if (o_valid !== (c >= 2)) begin bad++; $display("FAIL stream_valid c=%0d got=%b", c, o_valid); end
         if (c >= 2) begin
            total++;
            if (o_id !== 2'((c - 2) % 4) || o_c !== 40'(10 * ((c - 2) % 4 + 1))) begin
               bad++; $display("FAIL stream_out c=%0d got=(%0d,%0d) want=(%0d,%0d)", c, o_id, o_c,
                               (c - 2) % 4, 10 * ((c - 2) % 4 + 1));
            end
         end
         tick();
      end
      req_valid = '0; tick(); tick();
   endtask

   task automatic test_stall();
      int g;
      int o;
      logic rdy;
      do_reset();
      for (int k = 0; k < 4; k++) set_req(k, k + 1, 10);
      req_valid = 4'b1111;
      g = 0; o = 0;
      for (int c = 0; c < 14; c++) begin
         rdy = !(c >= 5 && c <= 7);
         i_ready = rdy;
         #1;
         total++;
         if (o_req_ready !== (rdy ? 4'(1 << (g % 4)) : 4'b0000)) begin
            bad++; $display("FAIL stall_grant c=%0d got=%b want=%b", c, o_req_ready,
                            rdy ? 4'(1 << (g % 4)) : 4'b0000);
         end
         if (rdy) g++;
         total++;
         if (o_valid !== (c >= 2)) begin bad++; $display("FAIL stall_valid c=%0d got=%b", c, o_valid); end
         if (c >= 2) begin
            total++;
            if (o_id !== 2'(o % 4) || o_c !== 40'(10 * (o % 4 + 1))) begin
               bad++; $display("FAIL stall_out c=%0d got=(%0d,%0d) want=(%0d,%0d)", c, o_id, o_c,
                               o % 4, 10 * (o % 4 + 1));
            end
            if (rdy) o++;
         end
         tick();
      end
      req_valid = '0; i_ready = 1'b1; tick(); tick();
   endtask

   task automatic test_extremes();
      longint exp1;
      longint exp2;
      exp1 = 64'sd274877906944;
      exp2 = -64'sd274869518336;
      do_reset();
      set_req(0, -32768, -8388608); req_valid = 4'b0001; i_ready = 1'b1;
      #1;
      total++; if (o_req_ready !== 4'b0001) begin bad++; $display("FAIL ext_grant0 got=%b want=0001", o_req_ready); end
      tick();
      set_req(0, 32767, -8388608); #1;
      total++; if (o_req_ready !== 4'b0001) begin bad++; $display("FAIL ext_grant1 got=%b want=0001", o_req_ready); end
      tick(); req_valid = '0;
      total++; if (o_valid !== 1'b1 || longint'(o_c) !== exp1) begin
         bad++; $display("FAIL ext_maxpos got=%0d want=%0d", o_c, exp1);
      end
      tick();
      total++; if (o_valid !== 1'b1 || longint'(o_c) !== exp2) begin
         bad++; $display("FAIL ext_maxneg got=%0d want=%0d", o_c, exp2);
      end
      tick();
   endtask

   task automatic test_rr_pointer();
      do_reset();
      set_req(1, 1, 1); set_req(3, 1, 1);
      req_valid = 4'b1010; i_ready = 1'b1;
      #1;
      total++; if (o_req_ready !== 4'b0010) begin bad++; $display("FAIL rr_first got=%b want=0010", o_req_ready); end
      tick(); #1;
      total++; if (o_req_ready !== 4'b1000) begin bad++; $display("FAIL rr_second got=%b want=1000", o_req_ready); end
      tick(); #1;
      total++; if (o_req_ready !== 4'b0010) begin bad++; $display("FAIL rr_third got=%b want=0010", o_req_ready); end
      tick(); req_valid = '0; #1;
      total++; if (o_req_ready !== 4'b0000) begin bad++; $display("FAIL rr_idle got=%b want=0000", o_req_ready); end
      tick(); tick();
      req_valid = 4'b1010; #1;
      total++; if (o_req_ready !== 4'b1000) begin bad++; $display("FAIL rr_hold got=%b want=1000", o_req_ready); end
      tick(); req_valid = '0; tick(); tick();
   endtask

   task automatic test_mid_reset();
      do_reset();
      set_req(0, 2, 7); set_req(1, 4, 5);
      req_valid = 4'b0011; i_ready = 1'b1;
      tick(); tick();
      total++; if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
         bad++; $display("FAIL mrst_inflight got=%b%b want=11", o_valid, o_busy);
      end
      reset = 1'b1; #1;
      total++; if (o_req_ready !== 4'b0000) begin bad++; $display("FAIL mrst_ready got=%b want=0000", o_req_ready); end
      tick();
      total++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_c !== 40'sd0) begin
         bad++; $display("FAIL mrst_flush got=v%b b%b c%0d want=v0 b0 c0", o_valid, o_busy, o_c);
      end
      reset = 1'b0; #1;
      total++; if (o_req_ready !== 4'b0001) begin bad++; $display("FAIL mrst_prio got=%b want=0001", o_req_ready); end
      tick(); req_valid = '0; #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mrst_stale got=%b want=0", o_valid); end
      tick();
      total++; if (o_valid !== 1'b1 || o_id !== 2'd0 || o_c !== 40'sd14) begin
         bad++; $display("FAIL mrst_out got=v%b id%0d c%0d want=v1 id0 c14", o_valid, o_id, o_c);
      end
      tick();
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; i_ready = 1'b1;
      test_reset();
      test_single();
      test_stream();
      test_stall();
      test_extremes();
      test_rr_pointer();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
